dense_cmd_encoder: RTL
======================

Name: dense_cmd_encoder

Overview:
Command sequencer/encoder that produces the per-cycle command fields consumed by the dense decode stage: act_type, dense_type, cost_type, w, w_layer_index, w_row_index, is_update, load_w, backprop_cost, x and label.
On start it walks every layer/row and fetches weights from weight memory, issuing one load_w command per row. It then accepts one sample (x, label) and issues a forward command, followed by backprop and update commands when training.
It sits between host control/sample source and the decode register stage.

Parameters:
size, 3, elements per vector (weight row, x, label)
data_size, 16, bits per element
cost_type_size, 8, cost type field width
dense_type_size, 4, dense type field width
act_type_size, 4, activation type field width
num_layers, 2, number of dense layers to load (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a sequence when idle
cfg_act_type  in  act_type_size  activation type, latched at start
cfg_dense_type  in  dense_type_size  dense type, latched at start
cfg_cost_type  in  cost_type_size  cost type, latched at start
cfg_train  in  1  1 = issue backprop and update after forward; latched at start
cfg_reload  in  1  force weight reload (used only with SKIP_RELOAD_EN)
w_rd_req  out  1  weight-row read request
w_rd_layer  out  32  layer index of request
w_rd_row  out  32  row index of request
w_rd_valid  in  1  read data valid, one-cycle pulse
w_rd_data  in  data_size*size  weight row data
x_valid  in  1  sample valid
x_ready  out  1  sample accept
x_in  in  data_size*size  sample input
label_in  in  data_size*size  sample label
cmd_valid  out  1  command valid
cmd_ready  in  1  downstream accept
act_type, dense_type, cost_type  out  act_type_size, dense_type_size, cost_type_size  command fields (latched cfg values)
w  out  data_size*size  weight row
w_layer_index, w_row_index  out  32 each  weight position
is_update, load_w, backprop_cost  out  1 each  command control bits
x, label  out  data_size*size each  sample fields
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at end of sequence

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, indices 0, cfg registers 0. Reset mid-sequence aborts without completion; done is not pulsed.
- States: IDLE, LD_REQ, LD_WAIT, LD_ISSUE, X_WAIT, FWD, BP, UPD, DONE.
- IDLE: on start=1, latch cfg_* and go to LD_REQ with layer=0, row=0. start while busy is ignored.
- LD_REQ: assert w_rd_req for exactly 1 cycle with w_rd_layer/w_rd_row = current indices, then go to LD_WAIT.
- LD_WAIT: on w_rd_valid, capture w_rd_data into w, set w_layer_index/w_row_index, go to LD_ISSUE. w_rd_valid outside LD_WAIT is ignored.
- LD_ISSUE: cmd_valid=1, load_w=1, is_update=0, backprop_cost=0.
  - On cmd_valid&&cmd_ready, advance row. row==size-1 wraps to 0 and increments layer.
  - After the last row of layer num_layers-1, go to X_WAIT; otherwise go to LD_REQ.
- X_WAIT: x_ready=1. On x_valid, capture x_in/label_in and go to FWD.
- FWD: cmd_valid=1, all control bits 0. On accept, go to BP if cfg_train, else DONE.
- BP: cmd_valid=1, backprop_cost=1. On accept, go to UPD.
- UPD: cmd_valid=1, is_update=1. On accept, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Handshake:
  - While cmd_valid=1 and cmd_ready=0, every command field and cmd_valid are held stable.
  - cmd_valid drops the cycle after accept unless the next state issues immediately. Back-to-back issue is not required.
  - A command is issued only from LD_ISSUE, FWD, BP and UPD.
- act_type/dense_type/cost_type always drive the latched cfg values while busy.
- Total load commands per sequence = num_layers*size. Indices are zero-extended to 32 bits.

Optional Feature:
SKIP_RELOAD_EN:
- Defined: a weights_loaded flag is set after the first completed load phase and cleared by reset. On start, if weights_loaded=1 and cfg_reload=0, the FSM goes directly from IDLE to X_WAIT. Otherwise it loads as normal.
- Undefined: cfg_reload is ignored and every start reloads all weights.

Test Plan:
- Defaults, start with cfg_train=0, cmd_ready=1, w_rd_valid 2 cycles after each req -> 6 load_w commands with (layer,row) = (0,0)..(1,2) in order, then 1 forward command with load_w=0, then done pulses once and busy=0.
- cfg_train=1 -> after forward, backprop_cost=1 command then is_update=1 command, then done; x/label equal the captured sample (e.g. x_in=48'h0001_0002_0003).
- cmd_ready held 0 for 5 cycles during the load of (1,1) -> cmd_valid stays 1 and w/w_layer_index=1/w_row_index=1 stay unchanged; exactly one command is accepted.
- start pulsed while busy and extra w_rd_valid pulses in X_WAIT -> no effect on sequence or command count.
- rst_n low mid-LD_WAIT -> all outputs 0 immediately (async), then IDLE; a new start restarts from (0,0).
- SKIP_RELOAD_EN: second start with cfg_reload=0 -> no w_rd_req and no load commands; with cfg_reload=1 -> full 6-row reload.

Source files
------------

// File: rtl/dense_cmd_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dense_cmd_encoder                                               |
// | Purpose  : Command sequencer for the dense decode stage. On start, it      |
// |            fetches every weight row and issues one load_w command per      |
// |            row. It then accepts one sample and issues a forward command,   |
// |            followed by backprop and update commands when training.         |
// | Options  : define SKIP_RELOAD_EN to skip the weight load phase on later    |
// |            starts once weights are resident, unless cfg_reload is set.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dense_cmd_encoder #(
  parameter int SIZE            = 3,
  parameter int DATA_SIZE       = 16,
  parameter int COST_TYPE_SIZE  = 8,
  parameter int DENSE_TYPE_SIZE = 4,
  parameter int ACT_TYPE_SIZE   = 4,
  parameter int NUM_LAYERS      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ACT_TYPE_SIZE-1:0]    cfg_act_type,
  input  logic [DENSE_TYPE_SIZE-1:0]  cfg_dense_type,
  input  logic [COST_TYPE_SIZE-1:0]   cfg_cost_type,
  input  logic                        cfg_train,
  input  logic                        cfg_reload,
  output logic                        w_rd_req,
  output logic [31:0]                 w_rd_layer,
  output logic [31:0]                 w_rd_row,
  input  logic                        w_rd_valid,
  input  logic [DATA_SIZE*SIZE-1:0]   w_rd_data,
  input  logic                        x_valid,
  output logic                        x_ready,
  input  logic [DATA_SIZE*SIZE-1:0]   x_in,
  input  logic [DATA_SIZE*SIZE-1:0]   label_in,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic [ACT_TYPE_SIZE-1:0]    act_type,
  output logic [DENSE_TYPE_SIZE-1:0]  dense_type,
  output logic [COST_TYPE_SIZE-1:0]   cost_type,
  output logic [DATA_SIZE*SIZE-1:0]   w,
  output logic [31:0]                 w_layer_index,
  output logic [31:0]                 w_row_index,
  output logic                        is_update,
  output logic                        load_w,
  output logic                        backprop_cost,
  output logic [DATA_SIZE*SIZE-1:0]   x,
  output logic [DATA_SIZE*SIZE-1:0]   label,
  output logic                        busy,
  output logic                        done
);

  localparam int VW = DATA_SIZE * SIZE;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LD_REQ   = 4'd1,
    S_LD_WAIT  = 4'd2,
    S_LD_ISSUE = 4'd3,
    S_X_WAIT   = 4'd4,
    S_FWD      = 4'd5,
    S_BP       = 4'd6,
    S_UPD      = 4'd7,
    S_DONE     = 4'd8
  } state_t;

  state_t                       state_q, state_d;
  logic [ACT_TYPE_SIZE-1:0]     act_q;
  logic [DENSE_TYPE_SIZE-1:0]   dense_q;
  logic [COST_TYPE_SIZE-1:0]    cost_q;
  logic                         train_q;
  logic [31:0]                  layer_q, row_q;
  logic [VW-1:0]                w_q, x_q, label_q;
  logic [31:0]                  w_layer_q, w_row_q;
  logic                         last_row, last_layer;
  logic                         skip_load;

  assign last_row   = (row_q == 32'(SIZE - 1));
  assign last_layer = (layer_q == 32'(NUM_LAYERS - 1));

`ifdef SKIP_RELOAD_EN
  logic weights_loaded_q;

  // Remember that a full load phase has completed since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weights_loaded_q <= 1'b0;
    end else if (state_q == S_LD_ISSUE && cmd_ready && last_row && last_layer) begin
      weights_loaded_q <= 1'b1;
    end
  end

  assign skip_load = weights_loaded_q && !cfg_reload;
`else
  logic unused_reload;
  assign unused_reload = cfg_reload;
  assign skip_load     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and state-decoded control outputs.
  always_comb begin
    state_d       = state_q;
    w_rd_req      = 1'b0;
    x_ready       = 1'b0;
    cmd_valid     = 1'b0;
    load_w        = 1'b0;
    backprop_cost = 1'b0;
    is_update     = 1'b0;
    done          = 1'b0;
    busy          = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) state_d = skip_load ? S_X_WAIT : S_LD_REQ;
      end
      S_LD_REQ: begin
        w_rd_req = 1'b1;
        state_d  = S_LD_WAIT;
      end
      S_LD_WAIT: begin
        if (w_rd_valid) state_d = S_LD_ISSUE;
      end
      S_LD_ISSUE: begin
        cmd_valid = 1'b1;
        load_w    = 1'b1;
        if (cmd_ready) state_d = (last_row && last_layer) ? S_X_WAIT : S_LD_REQ;
      end
      S_X_WAIT: begin
        x_ready = 1'b1;
        if (x_valid) state_d = S_FWD;
      end
      S_FWD: begin
        cmd_valid = 1'b1;
        if (cmd_ready) state_d = train_q ? S_BP : S_DONE;
      end
      S_BP: begin
        cmd_valid     = 1'b1;
        backprop_cost = 1'b1;
        if (cmd_ready) state_d = S_UPD;
      end
      S_UPD: begin
        cmd_valid = 1'b1;
        is_update = 1'b1;
        if (cmd_ready) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Config latch, row walker and command payload capture; payload only
  // changes in non-issuing states so it is stable while a command stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q     <= '0;
      dense_q   <= '0;
      cost_q    <= '0;
      train_q   <= 1'b0;
      layer_q   <= '0;
      row_q     <= '0;
      w_q       <= '0;
      w_layer_q <= '0;
      w_row_q   <= '0;
      x_q       <= '0;
      label_q   <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        act_q   <= cfg_act_type;
        dense_q <= cfg_dense_type;
        cost_q  <= cfg_cost_type;
        train_q <= cfg_train;
        layer_q <= '0;
        row_q   <= '0;
      end
      if (state_q == S_LD_WAIT && w_rd_valid) begin
        w_q       <= w_rd_data;
        w_layer_q <= layer_q;
        w_row_q   <= row_q;
      end
      if (state_q == S_LD_ISSUE && cmd_ready) begin
        if (last_row) begin
          row_q   <= '0;
          layer_q <= layer_q + 32'd1;
        end else begin
          row_q <= row_q + 32'd1;
        end
      end
      if (state_q == S_X_WAIT && x_valid) begin
        x_q     <= x_in;
        label_q <= label_in;
      end
    end
  end

  assign w_rd_layer    = layer_q;
  assign w_rd_row      = row_q;
  assign act_type      = act_q;
  assign dense_type    = dense_q;
  assign cost_type     = cost_q;
  assign w             = w_q;
  assign w_layer_index = w_layer_q;
  assign w_row_index   = w_row_q;
  assign x             = x_q;
  assign label         = label_q;

endmodule
`default_nettype wire
